// File: rtl/rv_dbg_pkg.sv
// Shared debug-block definitions: register-file geometry, the register-dump
// FSM state encoding, and a saturating pointer increment helper.
package rv_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    // Next register index, pinned at the last index so the pointer never wraps.
    function automatic logic [REG_ADDR_W-1:0] sat_inc(
        input logic [REG_ADDR_W-1:0] p,
        input logic [REG_ADDR_W-1:0] lim
    );
        sat_inc = (p >= lim) ? lim : p + 1'b1;
    endfunction

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: on start, walks register indices
// FIRST_REG..LAST_REG through a combinational read port and streams each
// value out over a valid/ready interface, one word per cycle when the
// consumer keeps up. The read address always looks one register ahead of
// the word on the stream so the next word can be captured on the handshake.
module reg_dump_ctrl
    import rv_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]       rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [REG_ADDR_W-1:0] out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

    dump_state_t           state;
    dump_state_t           state_nxt;
    logic [REG_ADDR_W-1:0] ptr;
    logic [REG_ADDR_W-1:0] ptr_nxt;
    logic [REG_ADDR_W-1:0] ptr_inc;
    logic                  valid_nxt;
    logic [XLEN-1:0]       data_nxt;
    logic [REG_ADDR_W-1:0] idx_nxt;
    logic                  last_nxt;
    logic                  done_nxt;

    assign ptr_inc = sat_inc(ptr, LAST_A);
    assign busy    = (state == FETCH) || (state == SEND);

    // Read address: current pointer while fetching, one ahead while sending.
    always_comb begin
        rf_raddr = FIRST_A;
        case (state)
            FETCH:   rf_raddr = ptr;
            SEND:    rf_raddr = ptr_inc;
            default: rf_raddr = FIRST_A;
        endcase
    end

    // Next-state, pointer and stream-register update; abort beats a handshake.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        idx_nxt   = out_idx;
        last_nxt  = out_last;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    ptr_nxt   = FIRST_A;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                    ptr_nxt   = FIRST_A;
                end else begin
                    state_nxt = SEND;
                    valid_nxt = 1'b1;
                    data_nxt  = rf_rdata;
                    idx_nxt   = ptr;
                    last_nxt  = (ptr == LAST_A);
                end
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                    ptr_nxt   = FIRST_A;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end else if (out_valid && out_ready) begin
                    if (ptr == LAST_A) begin
                        state_nxt = DONE;
                        ptr_nxt   = FIRST_A;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        ptr_nxt  = ptr_inc;
                        data_nxt = rf_rdata;
                        idx_nxt  = ptr_inc;
                        last_nxt = (ptr_inc == LAST_A);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = FIRST_A;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= FIRST_A;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_idx   <= idx_nxt;
            out_last  <= last_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed testbench for reg_dump_ctrl: a full 0..31 instance and a
// single-register (5..5) instance share one behavioural register file.
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, out_ready;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        out_valid, out_last, busy, done;
    logic [31:0] out_data;
    logic [4:0]  out_idx;

    logic        start_s, out_ready_s;
    logic [4:0]  rf_raddr_s;
    logic [31:0] rf_rdata_s;
    logic        out_valid_s, out_last_s, busy_s, done_s;
    logic [31:0] out_data_s;
    logic [4:0]  out_idx_s;

    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rf_rdata   = rf[rf_raddr];
    assign rf_rdata_s = rf[rf_raddr_s];

    reg_dump_ctrl #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    reg_dump_ctrl #(.FIRST_REG(5), .LAST_REG(5)) u_single (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .abort     (1'b0),
        .rf_raddr  (rf_raddr_s),
        .rf_rdata  (rf_rdata_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .out_data  (out_data_s),
        .out_idx   (out_idx_s),
        .out_last  (out_last_s),
        .busy      (busy_s),
        .done      (done_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int c;

        for (int i = 0; i < 32; i++) rf[i] = 32'(10 * i);
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_s = 1'b0; out_ready_s = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_idx",   {27'b0, out_idx}, 32'd0);
        chk("rst_last",  {31'b0, out_last}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_raddr", {27'b0, rf_raddr}, 32'd0);
        chk("rst_raddr_s", {27'b0, rf_raddr_s}, 32'd5);
        rst = 1'b0;
        tick();

        // Full dump, consumer always ready
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_fetch_busy",  {31'b0, busy}, 32'd1);
        chk("t1_fetch_valid", {31'b0, out_valid}, 32'd0);
        chk("t1_fetch_raddr", {27'b0, rf_raddr}, 32'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("t1_valid", {31'b0, out_valid}, 32'd1);
            chk("t1_idx",   {27'b0, out_idx}, 32'(i));
            chk("t1_data",  out_data, 32'(10 * i));
            chk("t1_last",  {31'b0, out_last}, (i == 31) ? 32'd1 : 32'd0);
            chk("t1_raddr", {27'b0, rf_raddr}, (i == 31) ? 32'd31 : 32'(i + 1));
            chk("t1_done0", {31'b0, done}, 32'd0);
            tick();
        end
        chk("t1_end_valid", {31'b0, out_valid}, 32'd0);
        chk("t1_done",      {31'b0, done}, 32'd1);
        chk("t1_end_busy",  {31'b0, busy}, 32'd0);
        chk("t1_end_last",  {31'b0, out_last}, 32'd0);
        chk("t1_end_raddr", {27'b0, rf_raddr}, 32'd0);
        tick();
        chk("t1_done_pulse", {31'b0, done}, 32'd0);

        // Dump with out_ready toggling
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        k = 0;
        c = 0;
        while (k < 32 && c < 200) begin
            out_ready = (c % 2 == 0);
            chk("t2_valid", {31'b0, out_valid}, 32'd1);
            chk("t2_idx",   {27'b0, out_idx}, 32'(k));
            chk("t2_data",  out_data, 32'(10 * k));
            chk("t2_last",  {31'b0, out_last}, (k == 31) ? 32'd1 : 32'd0);
            if (out_ready) k++;
            tick();
            c++;
        end
        chk("t2_words", 32'(k), 32'd32);
        chk("t2_done",  {31'b0, done}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t2_done_pulse", {31'b0, done}, 32'd0);

        // Late write to x7, then abort at the idx 10 handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i <= 10; i++) begin
            chk("t3_idx",  {27'b0, out_idx}, 32'(i));
            chk("t3_data", out_data, (i == 7) ? 32'hDEADBEEF : 32'(10 * i));
            if (i == 6) begin
                @(negedge clk);
                rf[7] = 32'hDEADBEEF;
            end
            if (i == 10) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("t3_abort_valid", {31'b0, out_valid}, 32'd0);
        chk("t3_abort_busy",  {31'b0, busy}, 32'd0);
        chk("t3_abort_done",  {31'b0, done}, 32'd0);
        chk("t3_abort_last",  {31'b0, out_last}, 32'd0);
        tick();
        chk("t3_abort_done2",  {31'b0, done}, 32'd0);
        chk("t3_abort_valid2", {31'b0, out_valid}, 32'd0);
        rf[7] = 32'd70;

        // Restart after abort, then reset mid-dump at idx 3
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_fetch_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("t4_restart_idx",  {27'b0, out_idx}, 32'd0);
        chk("t4_restart_data", out_data, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t4_idx", {27'b0, out_idx}, 32'(i));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_rst_data",  out_data, 32'd0);
        chk("t4_rst_idx",   {27'b0, out_idx}, 32'd0);
        chk("t4_rst_last",  {31'b0, out_last}, 32'd0);
        chk("t4_rst_busy",  {31'b0, busy}, 32'd0);
        chk("t4_rst_done",  {31'b0, done}, 32'd0);
        chk("t4_rst_raddr", {27'b0, rf_raddr}, 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t4_idle_busy",  {31'b0, busy}, 32'd0);
        chk("t4_idle_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_idle_done",  {31'b0, done}, 32'd0);

        // start while busy is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("t5_valid", {31'b0, out_valid}, 32'd1);
            chk("t5_idx",   {27'b0, out_idx}, 32'(i));
            chk("t5_data",  out_data, 32'(10 * i));
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        chk("t5_done", {31'b0, done}, 32'd1);
        tick();
        chk("t5_idle_busy", {31'b0, busy}, 32'd0);

        // Single-register dump (FIRST_REG = LAST_REG = 5)
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        chk("t6_busy",  {31'b0, busy_s}, 32'd1);
        chk("t6_raddr", {27'b0, rf_raddr_s}, 32'd5);
        tick();
        chk("t6_valid", {31'b0, out_valid_s}, 32'd1);
        chk("t6_idx",   {27'b0, out_idx_s}, 32'd5);
        chk("t6_data",  out_data_s, 32'd50);
        chk("t6_last",  {31'b0, out_last_s}, 32'd1);
        chk("t6_sraddr", {27'b0, rf_raddr_s}, 32'd5);
        tick();
        chk("t6_hold_valid", {31'b0, out_valid_s}, 32'd1);
        chk("t6_hold_data",  out_data_s, 32'd50);
        chk("t6_hold_last",  {31'b0, out_last_s}, 32'd1);
        chk("t6_hold_done",  {31'b0, done_s}, 32'd0);
        out_ready_s = 1'b1;
        tick();
        chk("t6_end_valid", {31'b0, out_valid_s}, 32'd0);
        chk("t6_done",      {31'b0, done_s}, 32'd1);
        chk("t6_end_last",  {31'b0, out_last_s}, 32'd0);
        tick();
        chk("t6_done_pulse", {31'b0, done_s}, 32'd0);
        chk("t6_idle_busy",  {31'b0, busy_s}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a dump in progress.
REQ-007 SHALL have port rf_raddr  output  5  read address to the register file read port.
REQ-008 SHALL have port rf_rdata  input  32  combinational read data returned for rf_raddr.
REQ-009 SHALL have port out_valid  output  1  stream word valid.
REQ-010 SHALL have port out_ready  input  1  stream consumer ready.
REQ-011 SHALL have port out_data  output  32  register contents.
REQ-012 SHALL have port out_idx  output  5  register index of out_data.
REQ-013 SHALL have port out_last  output  1  high with the word for LAST_REG.
REQ-014 SHALL have port busy  output  1  high in FETCH and SEND.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the LAST_REG word is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SEND and DONE.
REQ-017 IDLE: start=1 SHALL load ptr=FIRST_REG and go to FETCH; start in any other state SHALL be ignored.
REQ-018 FETCH: rf_raddr=ptr; next edge SHALL capture out_data=rf_rdata and out_idx=ptr, set out_valid=1, and go to SEND.
REQ-019 SEND: rf_raddr SHALL equal ptr+1, saturated at LAST_REG.
REQ-020 SEND with out_valid & out_ready and ptr!=LAST_REG SHALL capture the next word, increment ptr and stay in SEND, giving one word per cycle.
REQ-021 SEND with out_valid & out_ready and ptr==LAST_REG SHALL clear out_valid and go to DONE.
REQ-022 SEND with out_ready=0 SHALL hold out_valid, out_data, out_idx and out_last stable.
REQ-023 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 Latency SHALL be 2 cycles from the start edge to the first out_valid.
REQ-025 out_last SHALL equal (out_idx==LAST_REG) while out_valid=1, else 0.
REQ-026 abort=1 in FETCH or SEND SHALL return to IDLE next edge with out_valid=0 and no done pulse; abort SHALL have priority over a handshake in the same cycle.
REQ-027 Each word SHALL reflect register-file contents at its capture edge, including a write made on the preceding negedge.
REQ-028 rf_raddr SHALL be FIRST_REG in IDLE and DONE.
REQ-029 ptr arithmetic SHALL be 5-bit with no wrap past LAST_REG; FIRST_REG==LAST_REG SHALL produce a single word with out_last=1.

Reset
REQ-030 rst SHALL force IDLE, ptr=FIRST_REG, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0 and done=0, asynchronously.
REQ-031 rst mid-dump SHALL discard the dump without a done pulse; operation SHALL resume only on a new start after rst deasserts.

Structure
REQ-032 State enum, REG_ADDR_W=5 and XLEN=32 SHALL live in the shared package rv_dbg_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the FSM, pointer and output register are local.
REQ-034 Outputs out_* and done SHALL be registered; rf_raddr and busy SHALL be combinational from state and ptr.

Verification
REQ-035 Register file just reset (xi=10*i), start pulse, out_ready=1 -> 32 words idx 0..31, data 0,10,...,310, back-to-back, out_last on idx 31, done one cycle later.
REQ-036 Same as REQ-035 with out_ready toggling 1,0,1,0 -> no word lost or duplicated; data held stable while out_ready=0.
REQ-037 FIRST_REG=5, LAST_REG=5, start -> single word idx 5, data 50, out_last=1, then done.
REQ-038 Write x7=0xDEADBEEF on the negedge before idx 7 is captured -> word idx 7 = 0xDEADBEEF.
REQ-039 abort at the handshake of idx 10 -> out_valid=0 next cycle, no done, busy=0; new start restarts at idx 0.
REQ-040 rst asserted during SEND at idx 3 -> all outputs 0 immediately; start re-asserted while busy is ignored.
